// File: rtl/rx_iq_scheduler.sv
// RX I/Q sample FIFO that pops one sample per bus RX IQ read burst.
// Optional FIFO flush command enabled by RX_IQ_SCHED_FLUSH_EN.
module rx_iq_scheduler #(
  parameter int DEPTH_LOG2 = 4,
  parameter int CMD_RX_IQ  = 4,
  parameter int BURST_LEN  = 8
`ifdef RX_IQ_SCHED_FLUSH_EN
  , parameter int CMD_FLUSH = 5
`endif
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic [15:0]           ddc_i,
  input  logic [15:0]           ddc_q,
  input  logic                  ddc_valid,
  input  logic [3:0]            DATA_IN,
  input  logic                  DATA_SYNC,
  input  logic                  ovf_clear,
  output logic [15:0]           iq_i_out,
  output logic [15:0]           iq_q_out,
  output logic                  burst_active,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [7:0]            overflow_cnt,
  output logic                  underrun
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);
  localparam logic [3:0] RX_NIB = 4'(CMD_RX_IQ);

  typedef enum logic {IDLE, BURST} state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  logic [15:0] mem_i [DEPTH];
  logic [15:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0] lvl_base;
  logic [7:0] ovf_base;
  logic start, pop, push, drop, flush, urun_evt;

  assign start = DATA_SYNC && (DATA_IN == RX_NIB);

`ifdef RX_IQ_SCHED_FLUSH_EN
  assign flush = DATA_SYNC && (DATA_IN == 4'(CMD_FLUSH));
`else
  assign flush = 1'b0;
`endif

  assign pop      = start && (fifo_level != '0);
  assign urun_evt = start && (fifo_level == '0);

  // Flush or pop frees space before the same-cycle push is judged
  assign lvl_base = flush ? '0
                  : fifo_level - (DEPTH_LOG2+1)'(pop);
  assign push = ddc_valid && (lvl_base != FULL);
  assign drop = ddc_valid && !push;

  // Clear is applied before any same-cycle overflow event
  assign ovf_base = ovf_clear ? 8'd0 : overflow_cnt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = BURST;
      end
      BURST: begin
        if (DATA_SYNC) begin
          state_nx = start ? BURST : IDLE;
        end else if (cnt == LAST) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    burst_active = (state == BURST);
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_i[wr_ptr] <= ddc_i;
      mem_q[wr_ptr] <= ddc_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      iq_i_out     <= '0;
      iq_q_out     <= '0;
      overflow_cnt <= '0;
      underrun     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (flush) rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= lvl_base + (DEPTH_LOG2+1)'(push);
      if (pop) begin
        iq_i_out <= mem_i[rd_ptr];
        iq_q_out <= mem_q[rd_ptr];
      end
      if (drop && ovf_base != 8'hFF)
        overflow_cnt <= ovf_base + 8'd1;
      else
        overflow_cnt <= ovf_base;
      underrun <= urun_evt | (underrun & ~ovf_clear);
    end
  end

endmodule

// File: tb/tb_rx_iq_scheduler.sv
// Directed self-checking bench for rx_iq_scheduler.
// Flush checks are built only when RX_IQ_SCHED_FLUSH_EN is defined.
module tb_rx_iq_scheduler;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [15:0] ddc_i, ddc_q;
  logic        ddc_valid;
  logic [3:0]  DATA_IN;
  logic        DATA_SYNC;
  logic        ovf_clear;
  logic [15:0] iq_i_out, iq_q_out;
  logic        burst_active;
  logic [4:0]  fifo_level;
  logic [7:0]  overflow_cnt;
  logic        underrun;

  int ncmp = 0;
  int nerr = 0;

  rx_iq_scheduler dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .ddc_i(ddc_i),
    .ddc_q(ddc_q),
    .ddc_valid(ddc_valid),
    .DATA_IN(DATA_IN),
    .DATA_SYNC(DATA_SYNC),
    .ovf_clear(ovf_clear),
    .iq_i_out(iq_i_out),
    .iq_q_out(iq_q_out),
    .burst_active(burst_active),
    .fifo_level(fifo_level),
    .overflow_cnt(overflow_cnt),
    .underrun(underrun)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [15:0] i, input logic [15:0] q);
    ddc_valid = 1'b1;
    ddc_i = i;
    ddc_q = q;
    step();
    ddc_valid = 1'b0;
  endtask

  task automatic cmd(input logic [3:0] n);
    DATA_SYNC = 1'b1;
    DATA_IN = n;
    step();
    DATA_SYNC = 1'b0;
    DATA_IN = 4'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    ddc_i = '0;
    ddc_q = '0;
    ddc_valid = 1'b0;
    DATA_IN = '0;
    DATA_SYNC = 1'b0;
    ovf_clear = 1'b0;
    #2;
    chk("rst_i", iq_i_out, 0);
    chk("rst_q", iq_q_out, 0);
    chk("rst_burst", burst_active, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow_cnt, 0);
    chk("rst_urun", underrun, 0);
    @(negedge clk_in);
    rst_n = 1'b1;

    // basic burst
    push(16'h1111, 16'hAAAA);
    push(16'h2222, 16'hBBBB);
    push(16'h3333, 16'hCCCC);
    chk("lvl3", fifo_level, 3);
    cmd(4'h4);
    chk("b1_i", iq_i_out, 16'h1111);
    chk("b1_q", iq_q_out, 16'hAAAA);
    chk("b1_lvl", fifo_level, 2);
    chk("b1_act0", burst_active, 1);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("b1_act", burst_active, 1);
      chk("b1_hold_i", iq_i_out, 16'h1111);
    end
    step();
    chk("b1_end", burst_active, 0);

    // reset mid-burst
    cmd(4'h4);
    chk("b2_i", iq_i_out, 16'h2222);
    chk("b2_act", burst_active, 1);
    rst_n = 1'b0;
    #2;
    chk("mrst_act", burst_active, 0);
    chk("mrst_lvl", fifo_level, 0);
    chk("mrst_i", iq_i_out, 0);
    @(negedge clk_in);
    rst_n = 1'b1;

    // overflow: 17 pushes into 16 slots
    for (int k = 0; k < 17; k++)
      push(16'h0100 + 16'(k), 16'h8000 + 16'(k));
    chk("full_lvl", fifo_level, 16);
    chk("full_ovf", overflow_cnt, 1);
    cmd(4'h4);
    chk("ovf_rd_i", iq_i_out, 16'h0100);
    chk("ovf_rd_q", iq_q_out, 16'h8000);
    chk("ovf_rd_lvl", fifo_level, 15);
    push(16'h0200, 16'h7000);
    chk("refill_lvl", fifo_level, 16);

    // full + push + fresh-start pop in one cycle
    ddc_valid = 1'b1;
    ddc_i = 16'h0201;
    ddc_q = 16'h7001;
    DATA_SYNC = 1'b1;
    DATA_IN = 4'h4;
    step();
    ddc_valid = 1'b0;
    DATA_SYNC = 1'b0;
    DATA_IN = 4'h0;
    chk("pp_lvl", fifo_level, 16);
    chk("pp_ovf", overflow_cnt, 1);
    chk("pp_i", iq_i_out, 16'h0101);
    chk("pp_q", iq_q_out, 16'h8001);
    chk("pp_act", burst_active, 1);

    // fresh start at cnt 3, abort at cnt 2
    step();
    step();
    step();
    cmd(4'h4);
    chk("fs_i", iq_i_out, 16'h0102);
    chk("fs_q", iq_q_out, 16'h8002);
    chk("fs_lvl", fifo_level, 15);
    chk("fs_act", burst_active, 1);
    step();
    step();
    cmd(4'h1);
    chk("ab_act", burst_active, 0);
    chk("ab_i", iq_i_out, 16'h0102);
    step();
    chk("ab_act2", burst_active, 0);

    // drain then underrun
    DATA_SYNC = 1'b1;
    DATA_IN = 4'h4;
    repeat (15) step();
    chk("drain_lvl", fifo_level, 0);
    chk("drain_urun", underrun, 0);
    chk("drain_i", iq_i_out, 16'h0201);
    step();
    DATA_SYNC = 1'b0;
    DATA_IN = 4'h0;
    chk("ur_flag", underrun, 1);
    chk("ur_i", iq_i_out, 16'h0201);
    chk("ur_q", iq_q_out, 16'h7001);
    chk("ur_lvl", fifo_level, 0);
    chk("ur_act", burst_active, 1);
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    chk("clr_urun", underrun, 0);
    chk("clr_ovf", overflow_cnt, 0);

    // clear + underrun + push in one cycle
    ovf_clear = 1'b1;
    DATA_SYNC = 1'b1;
    DATA_IN = 4'h4;
    ddc_valid = 1'b1;
    ddc_i = 16'h0AAA;
    ddc_q = 16'h0BBB;
    step();
    ovf_clear = 1'b0;
    DATA_SYNC = 1'b0;
    DATA_IN = 4'h0;
    ddc_valid = 1'b0;
    chk("cu_urun", underrun, 1);
    chk("cu_lvl", fifo_level, 1);
    chk("cu_i", iq_i_out, 16'h0201);
    cmd(4'h4);
    chk("cu_rd_i", iq_i_out, 16'h0AAA);
    chk("cu_rd_q", iq_q_out, 16'h0BBB);
    chk("cu_rd_lvl", fifo_level, 0);

    // overflow saturation, then clear with same-cycle drop
    ddc_valid = 1'b1;
    for (int k = 0; k < 272; k++) begin
      ddc_i = 16'(k);
      ddc_q = 16'(k);
      step();
    end
    chk("sat_ovf", overflow_cnt, 255);
    chk("sat_lvl", fifo_level, 16);
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    ddc_valid = 1'b0;
    chk("clr_drop_ovf", overflow_cnt, 1);
    chk("clr_drop_lvl", fifo_level, 16);

`ifdef RX_IQ_SCHED_FLUSH_EN
    do_reset();
    for (int k = 0; k < 5; k++)
      push(16'h0500 + 16'(k), 16'h0600 + 16'(k));
    chk("fl_pre", fifo_level, 5);
    cmd(4'h5);
    chk("fl_lvl", fifo_level, 0);
    chk("fl_i", iq_i_out, 0);
    chk("fl_act", burst_active, 0);
    cmd(4'h4);
    chk("fl_urun", underrun, 1);
`else
    do_reset();
    push(16'h0500, 16'h0600);
    cmd(4'h5);
    chk("nofl_lvl", fifo_level, 1);
    chk("nofl_act", burst_active, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/rx_iq_scheduler.md
Name: rx_iq_scheduler

Overview:
- Sits between the DDC output (ddc_i/ddc_q/ddc_valid) and the STM32 nibble-bus interface.
- Buffers decimated RX I/Q samples in a small FIFO.
- Watches the bus command stream and, on each RX IQ read command, pops exactly one sample. That sample is held stable on iq_i_out/iq_q_out for the whole nibble burst.
- Reports FIFO level, overflow count and underrun status so firmware can pace its reads.

Parameters:
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 samples (one sample = 16-bit I plus 16-bit Q)
CMD_RX_IQ, 4, command nibble on DATA_IN (with DATA_SYNC=1) that starts an RX IQ burst
BURST_LEN, 8, nibbles per burst; output sample held for this many cycles after the command cycle
CMD_FLUSH, 5, command nibble that empties the FIFO (only with the optional feature)

Ports:
clk_in  in  1  system clock, same clock as the bus interface
rst_n  in  1  asynchronous active-low reset
ddc_i  in  16  signed I from DDC
ddc_q  in  16  signed Q from DDC
ddc_valid  in  1  one-cycle strobe, sample on ddc_i/ddc_q is valid
DATA_IN  in  4  STM32 bus nibble (shared with the bus interface)
DATA_SYNC  in  1  STM32 command strobe
ovf_clear  in  1  one-cycle pulse, clears overflow_cnt and underrun
iq_i_out  out  16  signed I presented to the bus interface
iq_q_out  out  16  signed Q presented to the bus interface
burst_active  out  1  high while a burst is in progress
fifo_level  out  DEPTH_LOG2+1  current number of stored samples
overflow_cnt  out  8  dropped-sample count, saturating
underrun  out  1  sticky flag: a burst started with the FIFO empty

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; FIFO pointers and level 0; state IDLE; burst counter 0.
  - Reset asserted mid-burst aborts the burst immediately; stored samples are discarded.
- FIFO:
  - Circular buffer with DEPTH_LOG2-bit read/write pointers that wrap naturally.
  - Level is tracked separately and ranges 0..2**DEPTH_LOG2.
- Push: ddc_valid=1 and level<depth -> write at wr_ptr, wr_ptr+1.
- Full: ddc_valid=1 and level==depth and no pop this cycle -> sample dropped (newest lost); overflow_cnt+1, saturating at 255.
- Pop: a burst-start command (below) and level>0 -> read at rd_ptr into iq_i_out/iq_q_out on that same clk_in edge, rd_ptr+1.
- Command cycle and bus timing:
  - The command cycle is DATA_SYNC=1 and DATA_IN==CMD_RX_IQ.
  - Outputs are valid from the cycle after the command, which is the first data-nibble cycle of the bus interface.
- Simultaneous push and pop:
  - Both are performed and the level is unchanged.
  - When full, the pop frees the slot, the push is accepted and no overflow is counted.
  - When empty, the pop sees level 0 (underrun), the push is stored and the level becomes 1.
- State machine:
  - IDLE: a command cycle -> pop (or underrun) and go to BURST with cnt=0. Any other DATA_SYNC nibble -> stay IDLE.
  - BURST: burst_active=1 and cnt increments each cycle; at cnt==BURST_LEN-1 go to IDLE.
  - BURST, DATA_SYNC=1 with any nibble: the burst is aborted. If the nibble is CMD_RX_IQ, the command is handled as a fresh start (pop, cnt=0, stay BURST); otherwise go to IDLE.
  - iq_*_out never change during BURST except on a fresh-start pop.
- Underrun:
  - Command cycle with level==0 -> underrun=1 and iq_*_out keep their previous values.
- ovf_clear:
  - Clears overflow_cnt and underrun.
  - If an overflow or underrun event occurs in the same cycle, the clear is applied first and then the event: overflow_cnt=1 / underrun=1.
- Width rules: samples are stored and forwarded bit-exact with no scaling, rounding or sign manipulation.

Optional Feature:
- Macro: RX_IQ_SCHED_FLUSH_EN.
- Defined:
  - DATA_SYNC=1 with DATA_IN==CMD_FLUSH while in IDLE sets rd_ptr=wr_ptr and level=0 on that edge.
  - A push in the same cycle is stored after the flush, giving level 1.
  - In BURST, the flush command aborts the burst to IDLE and then flushes.
  - Does not touch overflow_cnt, underrun or iq_*_out.
- Undefined: CMD_FLUSH is an ordinary non-RX command; no flush logic or parameter use is synthesized.

Test Plan:
- Reset, push 3 samples (I/Q = 0x1111/0xAAAA, 0x2222/0xBBBB, 0x3333/0xCCCC), sync nibble 4 -> next cycle iq_i_out=0x1111, iq_q_out=0xAAAA, fifo_level=2, burst_active=1 for 8 cycles then 0.
- Push 17 samples into a depth-16 FIFO without reading -> fifo_level=16, overflow_cnt=1; a subsequent read returns the first sample, not the 17th.
- Full FIFO, ddc_valid and a read command in the same cycle -> overflow_cnt unchanged, fifo_level stays 16.
- Read command with an empty FIFO -> underrun=1 and iq_*_out keep their old values; ovf_clear pulse -> underrun=0, overflow_cnt=0.
- Sync nibble 4 at burst cycle 3, then sync nibble 1 at cycle 2 of the new burst -> second pop occurs, cnt restarts at 0; nibble 1 returns state to IDLE, burst_active=0 next cycle.
- With RX_IQ_SCHED_FLUSH_EN: 5 samples stored, sync nibble 5 -> fifo_level=0; next read command sets underrun=1.
